// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, NOP encoding and
// the buffered {pc, instr} entry plus the buffer fill-state encoding.
package rv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Buffer occupancy as seen by the fetch control: EMPTY, PARTIAL or FULL.
  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_PARTIAL = 2'd1,
    FILL_FULL    = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; read data is the head entry, combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty & ~flush;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign push_ok = push & ~flush & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, captures the memory word each push and presents
// buffered {pc, instr} pairs to decode; redirects flush and reload the PC.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = rv_fetch_pkg::RESET_PC,
  parameter int unsigned  DEPTH    = 2,
  parameter int unsigned  XLEN     = rv_fetch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] Address,
  input  logic [XLEN-1:0] Instruction,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Decode handshake: an entry transfers on a rising edge where if_valid and
  // if_ready are both high and redirect is low; if_* are stable while
  // if_valid is high and if_ready is low.

  logic [XLEN-1:0]   fetch_pc;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  fill_state_e       fill_state;

  always_comb begin
    fill_state = FILL_PARTIAL;
    if (empty)                     fill_state = FILL_EMPTY;
    else if (count == CW'(DEPTH))  fill_state = FILL_FULL;
  end

  assign if_valid = (fill_state != FILL_EMPTY);
  assign pop      = if_valid & if_ready;
  assign push     = fetch_en & ~redirect & (~full | pop);
  assign Address  = fetch_pc;
  assign if_pc    = head[2*XLEN-1:XLEN];
  assign if_instr = head[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        fetch_pc <= XLEN'(RESET_PC);
    else if (redirect) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (push)     fetch_pc <= fetch_pc + XLEN'(4);
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc, Instruction}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC 0 and a
// wrap-around RESET_PC) share stimulus, each reading its own ROM.
module tb_instr_fetch_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_en;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            if_ready;

  logic [XLEN-1:0] addr_a, instr_a, pc_a, ins_a;
  logic            valid_a;
  logic [XLEN-1:0] addr_w, instr_w, pc_w, ins_w;
  logic            valid_w;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_pc;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // ROM word k = 32'h1000_0000 + k, 256 words, indexed by the word address.
  assign instr_a = 32'h1000_0000 + {24'd0, addr_a[9:2]};
  assign instr_w = 32'h1000_0000 + {24'd0, addr_w[9:2]};

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .Address(addr_a),
    .Instruction(instr_a), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(valid_a), .if_ready(if_ready), .if_pc(pc_a), .if_instr(ins_a)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .XLEN(XLEN)) dut_w (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .Address(addr_w),
    .Instruction(instr_w), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(valid_w), .if_ready(if_ready), .if_pc(pc_w), .if_instr(ins_w)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (valid_a !== 1'b0 || addr_a !== 32'h0 || pc_a !== 32'h0 || ins_a !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: valid=%b addr=%h pc=%h instr=%h, want 0/0/0/0", valid_a, addr_a, pc_a, ins_a);
    end
    tests++;
    if (addr_w !== 32'hFFFF_FFF8 || valid_w !== 1'b0) begin
      fails++;
      $display("FAIL reset_pc_param: addr=%h valid=%b, want fffffff8/0", addr_w, valid_w);
    end
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tests++;
      if (valid_a !== 1'b1 || pc_a !== 32'(4 * (k - 1)) ||
          ins_a !== 32'h1000_0000 + 32'(k - 1) || addr_a !== 32'(4 * k)) begin
        fails++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h addr=%h, want 1/%h/%h/%h", k, valid_a, pc_a, ins_a, addr_a,
                 32'(4 * (k - 1)), 32'h1000_0000 + 32'(k - 1), 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests++;
      if (valid_a !== 1'b1 || pc_a !== 32'h0) begin
        fails++;
        $display("FAIL stall_head[%0d]: valid=%b pc=%h, want 1/00000000", k, valid_a, pc_a);
      end
    end
    tests++;
    if (addr_a !== 32'h8) begin
      fails++;
      $display("FAIL stall_addr: addr=%h, want 00000008", addr_a);
    end
    for (int k = 1; k <= 4; k++) exp_q.push_back(32'(4 * k));
    if_ready = 1'b1;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      exp_pc = exp_q.pop_front();
      tests++;
      if (valid_a !== 1'b1 || pc_a !== exp_pc) begin
        fails++;
        $display("FAIL stall_resume: valid=%b pc=%h, want 1/%h", valid_a, pc_a, exp_pc);
      end
    end
  endtask

  task automatic test_redirect();
    // Entering with the buffer full (count 2) and if_ready high.
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    @(negedge clk);
    redirect = 1'b0;
    tests++;
    if (valid_a !== 1'b0 || addr_a !== 32'h40) begin
      fails++;
      $display("FAIL redirect_flush: valid=%b addr=%h, want 0/00000040", valid_a, addr_a);
    end
    @(negedge clk);
    tests++;
    if (valid_a !== 1'b1 || pc_a !== 32'h40 || ins_a !== 32'h1000_0010) begin
      fails++;
      $display("FAIL redirect_first: valid=%b pc=%h instr=%h, want 1/00000040/10000010", valid_a, pc_a, ins_a);
    end
    @(negedge clk);
    tests++;
    if (valid_a !== 1'b1 || pc_a !== 32'h44) begin
      fails++;
      $display("FAIL redirect_second: valid=%b pc=%h, want 1/00000044", valid_a, pc_a);
    end
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] wpc [3];
    logic [XLEN-1:0] wins [3];
    wpc[0] = 32'hFFFF_FFF8; wpc[1] = 32'hFFFF_FFFC; wpc[2] = 32'h0000_0000;
    wins[0] = 32'h1000_00FE; wins[1] = 32'h1000_00FF; wins[2] = 32'h1000_0000;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (valid_w !== 1'b1 || pc_w !== wpc[k] || ins_w !== wins[k]) begin
        fails++;
        $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", k, valid_w, pc_w, ins_w, wpc[k], wins[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (valid_a !== 1'b0 || addr_a !== 32'h0 || pc_a !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: valid=%b addr=%h pc=%h, want 0/0/0", valid_a, addr_a, pc_a);
    end
    @(negedge clk);
    rst_n = 1'b1; if_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (valid_a !== 1'b1 || pc_a !== 32'(4 * k)) begin
        fails++;
        $display("FAIL async_restart[%0d]: valid=%b pc=%h, want 1/%h", k, valid_a, pc_a, 32'(4 * k));
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fetch_en = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (valid_a !== 1'b1 || pc_a !== 32'h4 || addr_a !== 32'h8) begin
      fails++;
      $display("FAIL drain_one: valid=%b pc=%h addr=%h, want 1/00000004/00000008", valid_a, pc_a, addr_a);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (valid_a !== 1'b0 || addr_a !== 32'h8) begin
        fails++;
        $display("FAIL drain_empty[%0d]: valid=%b addr=%h, want 0/00000008", k, valid_a, addr_a);
      end
    end
    fetch_en = 1'b1;
    @(negedge clk);
    tests++;
    if (valid_a !== 1'b1 || pc_a !== 32'h8 || ins_a !== 32'h1000_0002 || addr_a !== 32'hC) begin
      fails++;
      $display("FAIL drain_resume: valid=%b pc=%h instr=%h addr=%h, want 1/00000008/10000002/0000000c",
               valid_a, pc_a, ins_a, addr_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the memory address. It captures the combinational instruction word the memory returns and buffers {pc, instr} pairs in a small FIFO. Decode consumes them over a valid/ready handshake; branch/jump redirects flush the buffer and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, prefetch buffer entries (power of 2, >=2)
XLEN, 32, address/instruction width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetching permitted; 0 = no new pushes, buffer drains normally
Address  output  XLEN  byte address to instruction memory; equals fetch_pc
Instruction  input  XLEN  word from instruction memory, valid combinationally in the same cycle as Address
redirect  input  1  flush and reload PC (branch/jump taken)
redirect_pc  input  XLEN  new PC when redirect=1
if_valid  output  1  head entry available to decode
if_ready  input  1  decode accepts head entry this cycle
if_pc  output  XLEN  PC of head entry
if_instr  output  XLEN  instruction of head entry

Behaviour:
- Reset (rst_n=0, async): fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0; if_valid=0, Address=RESET_PC, if_pc/if_instr=0. Takes effect immediately; any in-flight buffer contents discarded.
- pop = if_valid & if_ready. push = fetch_en & ~redirect & (count<DEPTH | pop).
- On push: FIFO[wr_ptr] <= {fetch_pc, Instruction}; wr_ptr++; fetch_pc <= fetch_pc+4.
- fetch_pc wraps modulo 2^XLEN: 32'hFFFF_FFFC + 4 = 0, no flag.
- Pointers wrap modulo DEPTH. Count is updated as count + push - pop. Count width is clog2(DEPTH)+1.
- Full, with pop in the same cycle: push still allowed, count unchanged.
- Full, without pop: no push, fetch_pc holds, Address stable.
- Empty: if_valid=0. if_pc/if_instr hold their last value (don't-care to decode). if_ready is ignored.
- if_valid = (count!=0). if_pc/if_instr are driven combinationally from FIFO[rd_ptr]. There is no bypass: Instruction never reaches decode in the cycle it is fetched.
- Latency: an instruction fetched at edge N is visible at if_* after edge N (1 cycle). With a continuously ready consumer, throughput is 1 instr/cycle.
- Redirect has top priority:
  - count<=0, pointers<=0, fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Any simultaneous push and pop are cancelled; decode must not treat a head presented in a redirect cycle as consumed.
  - if_valid=0 in the cycle after redirect. The first redirected instruction is valid one cycle later.
- redirect_pc[1:0] is ignored and forced to 00.
- fetch_en=0: fetch_pc holds and no push occurs. Pop continues, so the buffer drains.
- The state machine is implicit in count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH). Transitions follow push/pop as above; redirect forces EMPTY from any state.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - XLEN and RESET_PC defaults;
  - the NOP constant 32'h0000_0013;
  - the typedef fetch_entry_t {pc[XLEN-1:0], instr[XLEN-1:0]}.
- One sub-module, fetch_fifo: synchronous FIFO parameterised by DEPTH and entry width, with push/pop/flush inputs and count/full/empty outputs.
- The PC register, handshake logic and redirect logic stay in instr_fetch_unit.

Test Plan:
1. Reset then fetch_en=1, if_ready=1; ROM holds word k = 32'h1000_0000+k -> Address steps 0,4,8…; if_pc/if_instr = (0,32'h1000_0000), (4,32'h1000_0001)… one per cycle, first valid 1 cycle after reset release.
2. if_ready=0 for 5 cycles -> after 2 pushes count=2, Address frozen at 8, if_pc stays 0. Raising if_ready resumes 1/cycle with no lost or duplicated PCs.
3. Redirect with redirect_pc=32'h0000_0043 while full and if_ready=1 -> next cycle if_valid=0, Address=32'h40; following cycle if_pc=32'h40. The head present during the redirect cycle is not popped.
4. Wrap: RESET_PC=32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 in order, instructions matching ROM indices 254, 255, 0.
5. Assert rst_n=0 asynchronously mid-stream, between edges, with count=2 -> if_valid drops immediately and Address=RESET_PC. After release, the sequence restarts at RESET_PC.
6. fetch_en=0 with count=2 and if_ready=1 -> two entries drain, then if_valid=0. Address holds throughout. Re-enabling continues from the held PC.
